// File: rtl/puf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | puf_pkg : shared constants and FSM state type for the PUF sequencer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package puf_pkg;
    localparam int CH_WIDTH = 8;
    localparam logic [CH_WIDTH-1:0] LFSR_TAPS     = 8'hB8;
    localparam logic [CH_WIDTH-1:0] LFSR_ZERO_SUB = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        OUT  = 2'd3
    } state_t;
endpackage
`default_nettype wire

// File: rtl/puf_challenge_lfsr.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | puf_challenge_lfsr : right-shift Galois LFSR challenge generator     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module puf_challenge_lfsr
    import puf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                advance,
    input  logic [CH_WIDTH-1:0] seed,
    output logic [CH_WIDTH-1:0] load_value,
    output logic [CH_WIDTH-1:0] next_value
);
    logic [CH_WIDTH-1:0] r_state;

    // All-zero is the LFSR lock-up state, so a zero seed is substituted.
    assign load_value = (seed == '0) ? LFSR_ZERO_SUB : seed;
    assign next_value = (r_state >> 1) ^ (r_state[0] ? LFSR_TAPS : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= '0;
        end else if (load) begin
            r_state <= load_value;
        end else if (advance) begin
            r_state <= next_value;
        end
    end
endmodule
`default_nettype wire

// File: rtl/puf_eval_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | puf_eval_sequencer : challenge/pulse sequencer and majority voter    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module puf_eval_sequencer
    import puf_pkg::*;
#(
    parameter int VOTES     = 5,
    parameter int SETTLE    = 4,
    parameter int RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_WIDTH-1:0]  seed,
    output logic                 busy,
    output logic [CH_WIDTH-1:0]  puf_challenge,
    output logic                 puf_pulse,
    input  logic                 puf_response,
    output logic [RESP_BITS-1:0] resp_data,
    output logic [RESP_BITS-1:0] resp_unstable,
    output logic                 resp_valid,
    input  logic                 resp_ready
);
    localparam int VOTE_W = $clog2(VOTES + 1);
    localparam int PH_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SETTLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_BITS - 1);
    localparam logic [VOTE_W-1:0] VOTE_ALL  = VOTE_W'(VOTES);
    localparam logic [VOTE_W-1:0] VOTE_HALF = VOTE_W'(VOTES / 2);

    state_t              r_state, w_state_next;
    logic                r_sync_meta, r_sync;
    logic [PH_W-1:0]     r_phase;
    logic [VOTE_W-1:0]   r_votes, r_ones;
    logic [BIT_W-1:0]    r_bit_idx;
    logic                w_accept, w_sample, w_resolve, w_handshake, w_phase_last;
    logic [VOTE_W-1:0]   w_votes_inc, w_ones_inc;
    logic [CH_WIDTH-1:0] w_lfsr_load, w_lfsr_next;

    assign w_phase_last = (r_phase == PH_LAST);
    assign w_votes_inc  = r_votes + 1'b1;
    assign w_ones_inc   = r_ones + VOTE_W'(r_sync);
    assign puf_pulse    = (r_state == HIGH);

    puf_challenge_lfsr u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (w_accept),
        .advance    (w_resolve),
        .seed       (seed),
        .load_value (w_lfsr_load),
        .next_value (w_lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_resolve    = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = LOW;
                end
            end
            LOW: begin
                if (w_phase_last) w_state_next = HIGH;
            end
            HIGH: begin
                if (w_phase_last) begin
                    w_sample = 1'b1;
                    if (w_votes_inc < VOTE_ALL) begin
                        w_state_next = LOW;
                    end else begin
                        w_resolve    = 1'b1;
                        w_state_next = (r_bit_idx == BIT_LAST) ? OUT : LOW;
                    end
                end
            end
            OUT: begin
                if (resp_valid && resp_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta   <= 1'b0;
            r_sync        <= 1'b0;
            r_phase       <= '0;
            r_votes       <= '0;
            r_ones        <= '0;
            r_bit_idx     <= '0;
            busy          <= 1'b0;
            puf_challenge <= '0;
            resp_data     <= '0;
            resp_unstable <= '0;
            resp_valid    <= 1'b0;
        end else begin
            r_sync_meta <= puf_response;
            r_sync      <= r_sync_meta;

            if (r_state == LOW || r_state == HIGH) begin
                r_phase <= w_phase_last ? '0 : r_phase + 1'b1;
            end else begin
                r_phase <= '0;
            end

            if (w_accept) begin
                busy          <= 1'b1;
                puf_challenge <= w_lfsr_load;
                r_bit_idx     <= '0;
                r_votes       <= '0;
                r_ones        <= '0;
                resp_data     <= '0;
                resp_unstable <= '0;
            end

            if (w_sample) begin
                if (w_resolve) begin
                    r_votes                  <= '0;
                    r_ones                   <= '0;
                    resp_data[r_bit_idx]     <= (w_ones_inc > VOTE_HALF);
                    resp_unstable[r_bit_idx] <= (w_ones_inc != '0) && (w_ones_inc != VOTE_ALL);
                    // The challenge only moves on when another bit follows, so it
                    // holds its last value once the word is complete.
                    if (r_bit_idx != BIT_LAST) begin
                        r_bit_idx     <= r_bit_idx + 1'b1;
                        puf_challenge <= w_lfsr_next;
                    end
                end else begin
                    r_votes <= w_votes_inc;
                    r_ones  <= w_ones_inc;
                end
            end

            resp_valid <= (r_state == OUT) && !w_handshake;

            if (w_handshake) begin
                busy <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire
